// File: rtl/rectangle_round_engine.sv
// -----------------------------------------------------------------------------
// rectangle_round_engine
//   Iterative RECTANGLE-80 encryption datapath. It takes one 64-bit round key
//   per round from the upstream key scheduler over a valid/ready handshake.
//   It applies NR rounds of AddRoundKey / SubColumn / ShiftRow, followed by a
//   final key XOR. The ciphertext is held on a valid/ready output port.
//
//   Ports
//     clk        in   1   clock, rising edge
//     rst        in   1   asynchronous, active-high reset
//     start      in   1   begin a block with pt_data (only taken in IDLE)
//     pt_data    in   64  plaintext, sampled when start is accepted
//     rk_data    in   64  round key from the key scheduler
//     rk_valid   in   1   rk_data is valid
//     rk_ready   out  1   a key is consumed this cycle if rk_valid=1
//     ct_data    out  64  ciphertext (the working state register)
//     ct_valid   out  1   ct_data is valid; held until ct_ready
//     ct_ready   in   1   downstream accepts ct_data
//     busy       out  1   high in every state except IDLE
//     round_idx  out  5   index of the next round key expected (0..NR)
//
//   State layout: row0=s[15:0], row1=s[31:16], row2=s[47:32], row3=s[63:48].
//   Column j is the nibble {row3[j],row2[j],row1[j],row0[j]}, with row0 as LSB.
// -----------------------------------------------------------------------------
module rectangle_round_engine #(
  parameter int NR = 25  // full rounds; NR+1 keys per block (1..31)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] pt_data,
  input  logic [63:0] rk_data,
  input  logic        rk_valid,
  output logic        rk_ready,
  output logic [63:0] ct_data,
  output logic        ct_valid,
  input  logic        ct_ready,
  output logic        busy,
  output logic [4:0]  round_idx
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam logic [4:0] LAST_ROUND_IDX = 5'(NR - 1);
  localparam logic [4:0] FINAL_IDX      = 5'(NR);

  localparam logic [3:0] SBOX [16] = '{
    4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
    4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2
  };

  state_t      r_state, w_state_next;
  logic [63:0] r_s, w_s_next, w_round_out;
  logic [4:0]  r_round_idx, w_round_idx_next;

  // The S-box acts on each 4-bit column, one bit taken from each row.
  function automatic logic [63:0] sub_column(input logic [63:0] s);
    logic [63:0] res;
    logic [3:0]  nib;
    res = '0;
    for (int j = 0; j < 16; j++) begin
      nib         = SBOX[{s[48+j], s[32+j], s[16+j], s[j]}];
      res[j]      = nib[0];
      res[16 + j] = nib[1];
      res[32 + j] = nib[2];
      res[48 + j] = nib[3];
    end
    return res;
  endfunction

  // 16-bit left rotates: row1 by 1, row2 by 12 (= right 4), row3 by 13 (= right 3).
  function automatic logic [63:0] shift_row(input logic [63:0] s);
    return {s[50:48], s[63:51],   // row3 rotl 13
            s[35:32], s[47:36],   // row2 rotl 12
            s[30:16], s[31],      // row1 rotl 1
            s[15:0]};             // row0 unchanged
  endfunction

  assign w_round_out = shift_row(sub_column(r_s ^ rk_data));

  // NOTE: every signal assigned in always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next     = r_state;
    w_s_next         = r_s;
    w_round_idx_next = r_round_idx;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_s_next         = pt_data;
          w_round_idx_next = '0;
          w_state_next     = ST_ROUND;
        end
      end
      ST_ROUND: begin
        // rk_ready is high for the whole state, so rk_valid alone marks a transfer.
        if (rk_valid) begin
          w_s_next         = w_round_out;
          w_round_idx_next = r_round_idx + 5'd1;
          if (r_round_idx == LAST_ROUND_IDX) begin
            w_state_next = ST_FINAL;
          end
        end
      end
      ST_FINAL: begin
        if (rk_valid) begin
          w_s_next         = r_s ^ rk_data;
          w_round_idx_next = FINAL_IDX;
          w_state_next     = ST_OUT;
        end
      end
      ST_OUT: begin
        if (ct_ready) begin
          w_round_idx_next = '0;
          w_state_next     = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so that every
  // register samples its pre-edge inputs, whatever the evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_s         <= '0;
      r_round_idx <= '0;
    end else begin
      r_state     <= w_state_next;
      r_s         <= w_s_next;
      r_round_idx <= w_round_idx_next;
    end
  end

  // Outputs are decoded from registered state only. rk_ready therefore
  // never depends on rk_valid in the same cycle.
  assign rk_ready  = (r_state == ST_ROUND) || (r_state == ST_FINAL);
  assign busy      = (r_state != ST_IDLE);
  assign ct_valid  = (r_state == ST_OUT);
  assign ct_data   = r_s;
  assign round_idx = r_round_idx;

endmodule
